// File: rtl/m6809_bus_arbiter.sv
// Round-robin arbiter for the 6809 system bus: requests the bus from the CPU,
// grants one external master at a time and always returns the bus to the CPU between owners.
module m6809_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int OWN_W    = 2,
    parameter int HOLD_MAX = 255,
    parameter int TEN_W    = 8
) (
    input  logic             hsclk,
    input  logic             rst_b,
    input  logic [NREQ-1:0]  req_b,
    input  logic             ba,
    input  logic             bs,
    output logic             breq_b,
    output logic [NREQ-1:0]  gnt_b,
    output logic [OWN_W-1:0] owner,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_BA = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [NREQ-1:0]  req_p0;
    logic [NREQ-1:0]  req_s;
    logic             ba_p0;
    logic             ba_s;
    logic             bs_p0;
    logic             bs_s;

    logic [OWN_W-1:0] rr_ptr;
    logic [TEN_W-1:0] tenure;

    logic             breq_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic [OWN_W-1:0] owner_nxt;
    logic             busy_nxt;
    logic [OWN_W-1:0] rr_nxt;
    logic [TEN_W-1:0] tenure_nxt;

    logic [NREQ-1:0]  req_act;
    logic [NREQ-1:0]  owner_mask;
    logic             bus_granted;
    logic             owner_live;
    logic             others_pending;
    logic             hold_expired;
    logic [OWN_W-1:0] winner;
    logic [OWN_W:0]   cand;

    // Two-flop synchronisers: all asynchronous inputs are only used after these
    always_ff @(posedge hsclk or negedge rst_b) begin
        if (!rst_b) begin
            req_p0 <= '1;
            req_s  <= '1;
            ba_p0  <= 1'b0;
            ba_s   <= 1'b0;
            bs_p0  <= 1'b0;
            bs_s   <= 1'b0;
        end else begin
            req_p0 <= req_b;
            req_s  <= req_p0;
            ba_p0  <= ba;
            ba_s   <= ba_p0;
            bs_p0  <= bs;
            bs_s   <= bs_p0;
        end
    end

    assign req_act        = ~req_s;
    assign bus_granted    = ba_s & bs_s;
    assign owner_mask     = NREQ'(1) << owner;
    assign owner_live     = req_act[owner];
    assign others_pending = |(req_act & ~owner_mask);
    assign hold_expired   = (tenure == TEN_W'(HOLD_MAX));

    // Scan downward so the candidate nearest rr_ptr+1 is the last one to win
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = {1'b0, rr_ptr} + (OWN_W+1)'(i);
            if (cand >= (OWN_W+1)'(NREQ))
                cand = cand - (OWN_W+1)'(NREQ);
            if (req_act[cand[OWN_W-1:0]])
                winner = cand[OWN_W-1:0];
        end
    end

    always_ff @(posedge hsclk or negedge rst_b) begin
        if (!rst_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        breq_nxt   = breq_b;
        gnt_nxt    = gnt_b;
        owner_nxt  = owner;
        busy_nxt   = busy;
        rr_nxt     = rr_ptr;
        tenure_nxt = tenure;
        case (state)
            IDLE: begin
                if (|req_act) begin
                    owner_nxt = winner;
                    breq_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = WAIT_BA;
                end
            end
            WAIT_BA: begin
                if (!owner_live) begin
                    state_nxt = RELEASE;
                end else if (bus_granted) begin
                    gnt_nxt    = ~owner_mask;
                    tenure_nxt = '0;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (!hold_expired)
                    tenure_nxt = tenure + TEN_W'(1);
                // Owner drop, CPU reclaiming the bus, or tenure expiry with contenders
                if (!owner_live || !bus_granted || (hold_expired && others_pending)) begin
                    gnt_nxt   = '1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                breq_nxt = 1'b1;
                if (!ba_s) begin
                    rr_nxt    = owner;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hsclk or negedge rst_b) begin
        if (!rst_b) begin
            breq_b <= 1'b1;
            gnt_b  <= '1;
            owner  <= '0;
            busy   <= 1'b0;
            rr_ptr <= OWN_W'(NREQ-1);
            tenure <= '0;
        end else begin
            breq_b <= breq_nxt;
            gnt_b  <= gnt_nxt;
            owner  <= owner_nxt;
            busy   <= busy_nxt;
            rr_ptr <= rr_nxt;
            tenure <= tenure_nxt;
        end
    end

endmodule

// File: tb/tb_m6809_bus_arbiter.sv
// Bench for m6809_bus_arbiter: every change of the outputs is matched against a
// queue of expected output states, each tagged with the hsclk cycle it must appear in.
module tb_m6809_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int OWN_W    = 2;
    localparam int HOLD_MAX = 4;
    localparam int TEN_W    = 8;

    logic             hsclk = 1'b0;
    logic             rst_b;
    logic [NREQ-1:0]  req_b;
    logic             ba;
    logic             bs;
    logic             breq_b;
    logic [NREQ-1:0]  gnt_b;
    logic [OWN_W-1:0] owner;
    logic             busy;

    logic cpu_auto = 1'b0;
    logic ba_auto  = 1'b0;
    logic ba_man   = 1'b0;
    logic bs_man   = 1'b0;

    assign ba = cpu_auto ? ba_auto : ba_man;
    assign bs = cpu_auto ? ba_auto : bs_man;

    m6809_bus_arbiter #(
        .NREQ(NREQ), .OWN_W(OWN_W), .HOLD_MAX(HOLD_MAX), .TEN_W(TEN_W)
    ) dut (
        .hsclk(hsclk), .rst_b(rst_b), .req_b(req_b), .ba(ba), .bs(bs),
        .breq_b(breq_b), .gnt_b(gnt_b), .owner(owner), .busy(busy)
    );

    always #5 hsclk = ~hsclk;

    int cyc = 0;
    always @(posedge hsclk) cyc <= cyc + 1;

    // Simple CPU: releases the bus (BA=BS=1) whenever breq_b is low
    always @(posedge hsclk) begin
        #1;
        ba_auto = !breq_b;
    end

    typedef struct {
        string      name;
        logic       breq;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       busy;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  done = 1'b0;
    bit  reported = 1'b0;
    bit  first = 1'b1;
    logic [7:0] prev = '0;

    task automatic want(input string nm, input logic b, input logic [3:0] g,
                        input logic [1:0] o, input logic bz, input int at);
        ev_t e;
        e.name = nm; e.breq = b; e.gnt = g; e.own = o; e.busy = bz; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge hsclk);
        #2;
    endtask

    always @(negedge hsclk) begin : monitor
        logic [7:0] cur;
        ev_t e;
        cur = {breq_b, gnt_b, owner, busy};
        if (first || cur !== prev) begin
            first = 1'b0;
            prev  = cur;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected change @cyc %0d: breq_b=%b gnt_b=%b owner=%0d busy=%b, no change required",
                         cyc, breq_b, gnt_b, owner, busy);
            end else begin
                e = exp_q.pop_front();
                if (cur !== {e.breq, e.gnt, e.own, e.busy} || (e.at >= 0 && e.at != cyc)) begin
                    n_bad++;
                    $display("FAIL %s: got breq_b=%b gnt_b=%b owner=%0d busy=%b @cyc %0d, required breq_b=%b gnt_b=%b owner=%0d busy=%b @cyc %0d",
                             e.name, breq_b, gnt_b, owner, busy, cyc, e.breq, e.gnt, e.own, e.busy, e.at);
                end
            end
        end
        if (done && !reported) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: no change seen, required breq_b=%b gnt_b=%b owner=%0d busy=%b @cyc %0d",
                         e.name, e.breq, e.gnt, e.own, e.busy, e.at);
            end
            reported = 1'b1;
        end
    end

    int c;
    int b;
    logic [1:0] o;

    initial begin
        rst_b = 1'b0;
        req_b = '1;
        want("reset", 1'b1, 4'b1111, 2'd0, 1'b0, -1);
        go(3);
        rst_b = 1'b1;
        go(2);

        // Single request with a hand-driven CPU
        c = cyc; req_b = 4'b1110;
        want("t1 breq", 1'b0, 4'b1111, 2'd0, 1'b1, c+3);
        go(5);
        c = cyc; ba_man = 1'b1; bs_man = 1'b1;
        want("t1 gnt", 1'b0, 4'b1110, 2'd0, 1'b1, c+3);
        go(6);
        c = cyc; req_b = '1;
        want("t1 gnt off", 1'b0, 4'b1111, 2'd0, 1'b1, c+3);
        want("t1 breq off", 1'b1, 4'b1111, 2'd0, 1'b1, c+4);
        go(6);
        c = cyc; ba_man = 1'b0; bs_man = 1'b0;
        want("t1 idle", 1'b1, 4'b1111, 2'd0, 1'b0, c+3);
        go(5);

        // Round robin with all masters requesting, starting from reset
        rst_b = 1'b0;
        go(1);
        rst_b = 1'b1; cpu_auto = 1'b1;
        go(2);
        c = cyc; req_b = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            b = c + 3 + 13*k;
            o = 2'(k % 4);
            want($sformatf("rr%0d breq", k), 1'b0, 4'b1111, o, 1'b1, b);
            want($sformatf("rr%0d gnt", k), 1'b0, ~(4'b0001 << o), o, 1'b1, b+3);
            if (k < 4) begin
                want($sformatf("rr%0d revoke", k), 1'b0, 4'b1111, o, 1'b1, b+8);
                want($sformatf("rr%0d breq off", k), 1'b1, 4'b1111, o, 1'b1, b+9);
                want($sformatf("rr%0d idle", k), 1'b1, 4'b1111, o, 1'b0, b+12);
            end
        end
        go(b + 4 - cyc);
        req_b = '1;
        want("rr4 drop", 1'b0, 4'b1111, 2'd0, 1'b1, b+7);
        want("rr4 breq off", 1'b1, 4'b1111, 2'd0, 1'b1, b+8);
        want("rr4 idle", 1'b1, 4'b1111, 2'd0, 1'b0, b+11);
        go(14);

        // Sole holder keeps the bus, then a contender forces a revoke
        c = cyc; req_b = 4'b1011;
        want("sole breq", 1'b0, 4'b1111, 2'd2, 1'b1, c+3);
        want("sole gnt", 1'b0, 4'b1011, 2'd2, 1'b1, c+6);
        go(1006);
        c = cyc; req_b = 4'b1001;
        want("sole revoke", 1'b0, 4'b1111, 2'd2, 1'b1, c+3);
        want("sole breq off", 1'b1, 4'b1111, 2'd2, 1'b1, c+4);
        want("sole idle", 1'b1, 4'b1111, 2'd2, 1'b0, c+7);
        want("wrap breq", 1'b0, 4'b1111, 2'd1, 1'b1, c+8);
        want("wrap gnt", 1'b0, 4'b1101, 2'd1, 1'b1, c+11);
        go(12);
        rst_b = 1'b0; req_b = '1;
        want("async reset", 1'b1, 4'b1111, 2'd0, 1'b0, c+12);
        go(2);
        c = cyc; rst_b = 1'b1; req_b = 4'b0110;
        want("post-reset breq", 1'b0, 4'b1111, 2'd0, 1'b1, c+3);
        want("post-reset gnt", 1'b0, 4'b1110, 2'd0, 1'b1, c+6);
        go(7);
        req_b = '1;
        want("post-reset gnt off", 1'b0, 4'b1111, 2'd0, 1'b1, c+10);
        want("post-reset breq off", 1'b1, 4'b1111, 2'd0, 1'b1, c+11);
        want("post-reset idle", 1'b1, 4'b1111, 2'd0, 1'b0, c+14);
        go(16);

        // Withdraw before the CPU grants the bus
        cpu_auto = 1'b0; ba_man = 1'b0; bs_man = 1'b0;
        c = cyc; req_b = 4'b0111;
        want("wd breq", 1'b0, 4'b1111, 2'd3, 1'b1, c+3);
        go(5);
        req_b = '1;
        want("wd idle", 1'b1, 4'b1111, 2'd3, 1'b0, c+9);
        go(8);
        c = cyc; req_b = 4'b1100;
        want("after wd breq", 1'b0, 4'b1111, 2'd0, 1'b1, c+3);
        go(5);
        req_b = '1;
        want("after wd idle", 1'b1, 4'b1111, 2'd0, 1'b0, c+9);
        go(8);

        // Sub-cycle glitch is never sampled; a two-cycle pulse is
        req_b = 4'b1110;
        #4;
        req_b = '1;
        go(8);
        c = cyc; req_b = 4'b1110;
        want("pulse2 breq", 1'b0, 4'b1111, 2'd0, 1'b1, c+3);
        want("pulse2 idle", 1'b1, 4'b1111, 2'd0, 1'b0, c+6);
        go(2);
        req_b = '1;
        go(8);

        done = 1'b1;
        repeat (2) @(negedge hsclk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
